// File: rtl/memory_stage.sv
// Pipeline memory-access stage: EX/MEM register, req/ack data-memory port,
// branch resolution and the MEM/WB register, with a timeout watchdog.
module memory_stage #(
  parameter int MAX_WAIT = 15,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [6:0]        branch_pc,
  input  logic              zero,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       data2_out,
  input  logic [4:0]        dst,
  output logic              stall,
  output logic              pc_src,
  output logic [6:0]        pc_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_dst,
  output logic              wb_reg_write,
  output logic              bus_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // EX/MEM register: the fields still needed once the access completes
  logic [31:0] ex_alu;
  logic [4:0]  ex_dst;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_store;

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; blocking assignments would leak new values within the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      ex_alu        <= '0;
      ex_dst        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_store      <= 1'b0;
      stall         <= 1'b0;
      pc_src        <= 1'b0;
      pc_target     <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_dst        <= '0;
      wb_reg_write  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      pc_src   <= 1'b0;
      wb_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            ex_alu        <= alu_result;
            ex_dst        <= dst;
            ex_reg_write  <= reg_write;
            ex_mem_to_reg <= mem_to_reg;
            ex_store      <= mem_write;

            if (branch && zero) begin
              pc_src    <= 1'b1;
              pc_target <= branch_pc;
            end

            if (mem_read || mem_write) begin
              // A read+write combination resolves to a store via dmem_we.
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= alu_result[ADDR_W-1:0];
              dmem_wdata <= data2_out;
              stall      <= 1'b1;
              wait_cnt   <= '0;
            end else begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_result;
              wb_dst       <= dst;
              wb_reg_write <= reg_write;
            end
          end
        end

        ACCESS: begin
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            stall        <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= ex_mem_to_reg ? dmem_rdata : ex_alu;
            wb_dst       <= ex_dst;
            wb_reg_write <= ex_reg_write && !ex_store;
          end else if (wait_cnt == CNT_LAST) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            stall        <= 1'b0;
            bus_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_data      <= ex_alu;
            wb_dst       <= ex_dst;
            wb_reg_write <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory-access stage: consumes the execute stage's results (ALU result, store data, destination register, zero flag, branch target), holds them in the EX/MEM register and performs load/store transactions on a req/ack data-memory port. It also resolves branches (`pc_src`) and drives the MEM/WB register toward writeback. While a memory access is outstanding it stalls upstream stages.

## Interface
- `MAX_WAIT`, 15, maximum cycles in ACCESS before the access times out (≥1).
- `ADDR_W`, 7, data-memory address width; the address is `alu_result[ADDR_W-1:0]`.

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  execute outputs valid this cycle
- `mem_read`, `mem_write`, `branch`, `reg_write`, `mem_to_reg`  in  1 each  control bits travelling with the instruction
- `branch_pc`  in  7  branch target from execute
- `zero`  in  1  ALU zero flag
- `alu_result`  in  32  ALU result / memory address
- `data2_out`  in  32  store data
- `dst`  in  5  destination register
- `stall`  out  1  upstream must hold; `in_valid` is ignored while high
- `pc_src`  out  1  one-cycle pulse: take branch
- `pc_target`  out  7  branch target, valid with `pc_src`
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  ADDR_W  memory address
- `dmem_wdata`  out  32  store data
- `dmem_rdata`  in  32  load data, valid with `dmem_ack`
- `dmem_ack`  in  1  transaction complete
- `wb_valid`  out  1  MEM/WB entry valid (one-cycle pulse per instruction)
- `wb_data`  out  32  load data if `mem_to_reg`, else ALU result
- `wb_dst`  out  5  destination register
- `wb_reg_write`  out  1  writeback enable
- `bus_err`  out  1  sticky timeout flag

## Operation
- All outputs are registered. Reset (`rst`=0 at an edge) clears every output and counter to 0, sets state to IDLE, and drops any in-flight access without a writeback.
- States: IDLE, ACCESS.
- **IDLE**, edge with `in_valid`=1: latch all inputs into the EX/MEM register.
  - If `mem_read`|`mem_write` is set: go to ACCESS. Set `dmem_req`=1, `dmem_we`=`mem_write`, address and wdata from the latched values, `stall`=1, wait counter=0.
  - Otherwise: load MEM/WB directly. `wb_valid`=1, `wb_data`=`alu_result`, `wb_dst`=`dst`, `wb_reg_write`=`reg_write`.
  - Branch, in both cases: if `branch`&`zero`, `pc_src`=1 and `pc_target`=`branch_pc` for exactly one cycle.
  - `mem_read` and `mem_write` both set: treat as a store.
- **ACCESS**, on each edge:
  - If `dmem_ack`=1: drop `dmem_req` and `stall`, go to IDLE. Pulse `wb_valid`=1 with `wb_data`=`mem_to_reg ? dmem_rdata : alu_result` and `wb_reg_write`=latched `reg_write`. A store must not write the register file, regardless of the `reg_write` input.
  - Otherwise, if the wait counter equals `MAX_WAIT-1`: time out. Drop `dmem_req` and `stall`, set `bus_err`=1, pulse `wb_valid`=1 with `wb_reg_write`=0, go to IDLE.
  - Otherwise: increment the wait counter. `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` stay stable.
- `dmem_ack` is ignored in IDLE. `bus_err` clears only on reset.
- `wb_valid` and `pc_src` are single-cycle pulses. MEM/WB data fields hold their value between pulses.

## Timing
- Non-memory instruction: captured at edge N; `wb_*` and `pc_src` are valid after edge N. Latency 1, throughput 1 per cycle.
- Memory instruction: captured at edge N; `dmem_req` and `stall` are high after N.
  - With ack sampled at edge N+k (k≥1): `wb_valid` is high and `stall` low after N+k. A new instruction can be accepted at edge N+k+1.
  - With zero-wait memory (ack at N+1): 2-cycle latency, one stall cycle.
- Timeout: with no ack, `bus_err` and `wb_valid` assert after edge N+`MAX_WAIT`.
- Ack and timeout on the same edge: ack wins, no `bus_err`.
- `stall` is registered. Upstream sees it one cycle after the capture edge and must not present a new `in_valid` in the cycle immediately after issuing a memory op. The stage ignores `in_valid` whenever it is not in IDLE.

## Test plan
- **Reset.** Hold `rst`=0 for 2 edges. Then all outputs are 0, state is IDLE, and `bus_err`=0.
- **ALU op.** Drive `in_valid`, `reg_write`=1, `alu_result`=0x0000_0042, `dst`=5. After 1 edge: `wb_valid`=1, `wb_data`=0x42, `wb_dst`=5, `wb_reg_write`=1. After the next edge: `wb_valid`=0.
- **Load, ack after 3 cycles.** `mem_read`, `mem_to_reg`, `alu_result`=0x13, `dmem_rdata`=0xDEADBEEF at ack time.
  - `dmem_addr`=0x13, `dmem_we`=0, `stall`=1 for 3 cycles.
  - Then `wb_data`=0xDEADBEEF and `stall`=0.
- **Store with `reg_write`=1.** `data2_out`=0x1234, immediate ack. `dmem_we`=1, `dmem_wdata`=0x1234, then `wb_valid`=1 with `wb_reg_write`=0.
- **Branch.** `branch`=1, `zero`=1, `branch_pc`=0x2A: `pc_src` pulses 1 cycle with `pc_target`=0x2A. Repeat with `zero`=0: no pulse.
- **Timeout and reset mid-access.**
  - `MAX_WAIT`=4, no ack: after 4 edges `bus_err`=1, `dmem_req`=0, `wb_reg_write`=0.
  - Start another access and assert `rst`=0 at the second ACCESS edge: all outputs 0 and `bus_err` cleared. A late `dmem_ack` afterwards produces no `wb_valid`.
